// File: rtl/logic_unit_if.sv
// Operand/function/result bundle between the ALU decoder and the registered logic unit.
interface logic_unit_if #(
  parameter int unsigned IN1_WIDTH       = 16,
  parameter int unsigned IN2_WIDTH       = 16,
  parameter int unsigned LOGIC_OUT_WIDTH = 16
);
  logic [IN1_WIDTH-1:0]       in1;
  logic [IN2_WIDTH-1:0]       in2;
  logic [1:0]                 logic_fun;
  logic                       logic_en;
  logic [LOGIC_OUT_WIDTH-1:0] logic_out;
  logic                       logic_flag;

  modport master (
    output in1, in2, logic_fun, logic_en,
    input  logic_out, logic_flag
  );

  modport slave (
    input  in1, in2, logic_fun, logic_en,
    output logic_out, logic_flag
  );
endinterface

// File: rtl/logic_unit.sv
// Registered bitwise logic unit (AND/OR/NAND/NOR) with a result-valid flag.
module logic_unit #(
  parameter int unsigned IN1_WIDTH       = 16,
  parameter int unsigned IN2_WIDTH       = 16,
  parameter int unsigned LOGIC_OUT_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  logic_unit_if.slave  lu
);

  typedef enum logic [1:0] {
    FUN_AND  = 2'b00,
    FUN_OR   = 2'b01,
    FUN_NAND = 2'b10,
    FUN_NOR  = 2'b11
  } fun_e;

  logic [LOGIC_OUT_WIDTH-1:0] w_a;
  logic [LOGIC_OUT_WIDTH-1:0] w_b;
  logic [LOGIC_OUT_WIDTH-1:0] w_res;
  logic [LOGIC_OUT_WIDTH-1:0] r_out;
  logic                       r_flag;

  // Operands are zero-extended or truncated to the result width.
  assign w_a = LOGIC_OUT_WIDTH'(lu.in1);
  assign w_b = LOGIC_OUT_WIDTH'(lu.in2);

  always_comb begin
    w_res = '0;
    unique case (fun_e'(lu.logic_fun))
      FUN_AND:  w_res = w_a & w_b;
      FUN_OR:   w_res = w_a | w_b;
      FUN_NAND: w_res = ~(w_a & w_b);
      FUN_NOR:  w_res = ~(w_a | w_b);
      default:  w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_flag <= 1'b0;
    end else if (lu.logic_en) begin
      r_out  <= w_res;
      r_flag <= 1'b1;
    end else begin
      r_out  <= '0;
      r_flag <= 1'b0;
    end
  end

  assign lu.logic_out  = r_out;
  assign lu.logic_flag = r_flag;

endmodule

// File: tb/tb_logic_unit.sv
// Scoreboard bench for logic_unit: expected {flag,out} queued at drive time, compared after the edge.
module tb_logic_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_unit_if #(.IN1_WIDTH(16), .IN2_WIDTH(16), .LOGIC_OUT_WIDTH(16)) lu ();

  logic_unit #(.IN1_WIDTH(16), .IN2_WIDTH(16), .LOGIC_OUT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .lu  (lu)
  );

  typedef struct {
    string       tag;
    logic [16:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got flag/out %h, expected %h", tag, got, exp);
    end
  endtask

  // Independent reference for the {flag, out} pair after one edge.
  function automatic logic [16:0] model(input bit r, input bit en, input bit [1:0] f,
                                        input bit [15:0] a, input bit [15:0] b);
    bit [15:0] res;
    if (r || !en) return 17'h0;
    case (f)
      2'b00: res = a & b;
      2'b01: res = a | b;
      2'b10: res = ~(a & b);
      default: res = ~(a | b);
    endcase
    return {1'b1, res};
  endfunction

  task automatic step(input string tag, input bit r, input bit en, input bit [1:0] f,
                      input bit [15:0] a, input bit [15:0] b, input logic [16:0] exp);
    exp_t e;
    rst          = r;
    lu.logic_en  = en;
    lu.logic_fun = f;
    lu.in1       = a;
    lu.in2       = b;
    sb.push_back('{tag, exp});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 17'h0, 17'h1FFFF);
    end else begin
      e = sb.pop_front();
      check(e.tag, {lu.logic_flag, lu.logic_out}, e.exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);

    step("reset",   1, 1, 2'b01, 16'hFFFF, 16'hFFFF, 17'h0_0000);
    step("and",     0, 1, 2'b00, 16'h000B, 16'h0009, 17'h1_0009);
    step("or",      0, 1, 2'b01, 16'h000B, 16'h0009, 17'h1_000B);
    step("nand",    0, 1, 2'b10, 16'h000B, 16'h0009, 17'h1_FFF6);
    step("nor",     0, 1, 2'b11, 16'h000B, 16'h0009, 17'h1_FFF4);
    step("disable", 0, 0, 2'b10, 16'h1234, 16'h5678, 17'h0_0000);
    step("reenable",0, 1, 2'b00, 16'hA5A5, 16'h0FF0, 17'h1_05A0);

    // Function change between edges must not reach the output.
    lu.logic_fun = 2'b01;
    #3;
    check("hold_midcycle", {lu.logic_flag, lu.logic_out}, 17'h1_05A0);
    @(posedge clk);
    #1;
    check("after_fun_change", {lu.logic_flag, lu.logic_out}, 17'h1_AFF5);

    // Reset in the middle of an enabled stream.
    step("stream0",  0, 1, 2'b11, 16'h00F0, 16'h0F00, 17'h1_F00F);
    step("rst_mid",  1, 1, 2'b01, 16'hFFFF, 16'h0000, 17'h0_0000);
    step("resume",   0, 1, 2'b01, 16'h8001, 16'h0100, 17'h1_8101);

    // Randomised back-to-back traffic.
    for (int i = 0; i < 60; i++) begin
      bit        r, en;
      bit [1:0]  f;
      bit [15:0] a, b;
      r  = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 4) != 0);
      f  = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = 16'($urandom);
      step("random", r, en, f, a, b, model(r, en, f, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/logic_unit.md
# logic_unit

Registered bitwise logic unit of the 16-bit ALU. When enabled, it computes one of four bitwise functions of two operands (AND, OR, NAND, NOR). The result and a valid flag are registered on the rising clock edge. It sits beside the arithmetic, shift and compare units behind the ALU decoder, which drives `logic_en` and `logic_fun`.

## Interface
Parameters:
- `IN1_WIDTH`, default 16: width of operand `in1`.
- `IN2_WIDTH`, default 16: width of operand `in2`.
- `LOGIC_OUT_WIDTH`, default 16: width of `logic_out`.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in1`, input, IN1_WIDTH: operand A.
- `in2`, input, IN2_WIDTH: operand B.
- `logic_fun`, input, 2: function select.
- `logic_en`, input, 1: unit enable from the ALU decoder.
- `logic_out`, output, LOGIC_OUT_WIDTH: registered result.
- `logic_flag`, output, 1: registered result-valid flag.

## Operation
- Operand sizing:
  - Each operand is zero-extended or truncated to LOGIC_OUT_WIDTH before the operation.
  - With the defaults, operands are used as-is.
- Function encoding (`logic_fun`):
  - 00: `in1 & in2` (AND)
  - 01: `in1 | in2` (OR)
  - 10: `~(in1 & in2)` (NAND)
  - 11: `~(in1 | in2)` (NOR)
- Result and flag are computed combinationally and captured in output registers. No combinational path runs from any input to `logic_out` or `logic_flag`.
- `logic_en` = 1 at a rising edge: `logic_out` ← selected function; `logic_flag` ← 1.
- `logic_en` = 0 at a rising edge: `logic_out` ← 0; `logic_flag` ← 0.
- No internal state beyond the two output registers; no FSM.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on the outputs immediately after edge N and hold until edge N+1.
- Reset:
  - `rst` = 1 at a rising edge forces `logic_out` = 0 and `logic_flag` = 0.
  - Reset has priority over `logic_en` and over any function select.
  - Asserting `rst` mid-operation discards the pending result at that edge.
- Power-up before the first reset edge: outputs undefined. Benches must reset, or must drive `logic_en` for at least one edge, before checking outputs.
- Back-to-back operations: a new function and new operands may be applied every cycle. Each edge's output reflects only that edge's sampled inputs.
- Changes to `logic_fun`, `in1` or `in2` between edges have no effect on the outputs until the next rising edge.
- Throughput: one result per cycle; no handshake or back-pressure.

## Test plan
- Reset:
  - Stimulus: `rst`=1, `logic_en`=1, `in1`=FFFF, `in2`=FFFF, `logic_fun`=01 for one edge.
  - Required: `logic_out`=0000, `logic_flag`=0.
- AND:
  - Stimulus: `logic_en`=1, `in1`=000B, `in2`=0009, `logic_fun`=00.
  - Required after the next edge: `logic_out`=0009, `logic_flag`=1.
- OR:
  - Stimulus: same operands, `logic_fun`=01.
  - Required after the next edge: `logic_out`=000B, `logic_flag`=1.
- NAND and NOR:
  - Stimulus: same operands, `logic_fun`=10, then `logic_fun`=11 on the following cycle.
  - Required: `logic_out`=FFF6, then FFF4; `logic_flag`=1 both cycles.
- Disable:
  - Stimulus: `logic_en`=0 with any operands and function.
  - Required after the next edge: `logic_out`=0000, `logic_flag`=0.
  - Stimulus: re-assert `logic_en`=1 with `in1`=A5A5, `in2`=0FF0, `logic_fun`=00.
  - Required one edge later: `logic_out`=05A0.
- Registered behaviour:
  - Stimulus: change `logic_fun` mid-cycle.
  - Required: `logic_out` holds its value until the next rising edge.
  - Stimulus: assert `rst` during a stream of enabled operations.
  - Required: outputs clear at that edge, and results resume one edge after `rst` deasserts.
